// File: rtl/hdc_dataset_sequencer_pkg.sv
// Shared HDC definitions used by the dataset sequencer and the HDC core.
//   FEATURE_COUNT : number of 16-bit feature words per sample
//   phase_e       : run phase reported to the host (idle/train/test/done)
//   next_idx      : feature index increment with wrap after the last feature
package hdc_dataset_sequencer_pkg;

  localparam int FEATURE_COUNT = 8;
  localparam int FEATURE_W     = 16;
  localparam int LABEL_W       = 5;
  localparam int COUNT_W       = 11;
  localparam int IDX_W         = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;

  typedef enum logic [1:0] {
    PHASE_IDLE  = 2'd0,
    PHASE_TRAIN = 2'd1,
    PHASE_TEST  = 2'd2,
    PHASE_DONE  = 2'd3
  } phase_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(FEATURE_COUNT - 1)) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/hdc_dataset_sequencer.sv
// Dataset sequencer for a one-shot HDC core.
// Streams TRAIN_COUNT training samples and then TEST_COUNT testing samples
// from a host into a feature buffer, launches the core once per sample and
// tracks the phase handshakes with the core.
//
// Ports
//   clk, nrst                  : clock, asynchronous active-low reset
//   en                         : global enable; low freezes all state and pulses
//   run                        : one-cycle start pulse (IDLE), or clear pulse (DONE)
//   s_valid/s_ready            : host feature-word handshake
//   s_feature, s_label         : feature word (index order), label (with index 0)
//   input_values               : assembled sample, feature i at bits [16*i +: 16]
//   class_select_bits          : label of the current sample
//   start_mapping              : one-cycle launch pulse to the core
//   sample_done                : core finished encoding the current sample
//   class_gen_done             : core finished building class hypervectors
//   training_dataset_finished  : one-cycle pulse at the end of the training set
//   testing_dataset_finished   : one-cycle pulse at the end of the testing set
//   oneshot_hdc_done           : core finished the whole run
//   phase, sample_count        : run phase and samples completed in this phase
//   seq_done                   : run complete, waiting for the next run pulse
module hdc_dataset_sequencer
  import hdc_dataset_sequencer_pkg::*;
#(
  parameter int TRAIN_COUNT = 100,
  parameter int TEST_COUNT  = 100
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              en,
  input  logic                              run,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [FEATURE_W-1:0]              s_feature,
  input  logic [LABEL_W-1:0]                s_label,
  output logic [FEATURE_W*FEATURE_COUNT-1:0] input_values,
  output logic [LABEL_W-1:0]                class_select_bits,
  output logic                              start_mapping,
  input  logic                              sample_done,
  input  logic                              class_gen_done,
  output logic                              training_dataset_finished,
  output logic                              testing_dataset_finished,
  input  logic                              oneshot_hdc_done,
  output logic [1:0]                        phase,
  output logic [COUNT_W-1:0]                sample_count,
  output logic                              seq_done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT,
    ST_TRAIN_END,
    ST_GEN_WAIT,
    ST_TEST_END,
    ST_CORE_WAIT,
    ST_DONE
  } state_e;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FEATURE_COUNT - 1);
  localparam logic [COUNT_W-1:0] TRAIN_LIM = COUNT_W'(TRAIN_COUNT);
  localparam logic [COUNT_W-1:0] TEST_LIM  = COUNT_W'(TEST_COUNT);

  state_e               state_q, state_d;
  phase_e               phase_q;
  logic [IDX_W-1:0]     idx_q;
  logic [COUNT_W-1:0]   count_q;
  logic [COUNT_W-1:0]   count_inc;
  logic [LABEL_W-1:0]   label_q;
  logic [FEATURE_W-1:0] feat_q [FEATURE_COUNT];

  assign count_inc         = count_q + 1'b1;
  assign phase             = phase_q;
  assign sample_count      = count_q;
  assign class_select_bits = label_q;

  for (genvar g = 0; g < FEATURE_COUNT; g++) begin : g_pack
    assign input_values[g*FEATURE_W +: FEATURE_W] = feat_q[g];
  end

  // Next state and strobes. Strobes are gated by en so a frozen sequencer
  // neither completes a handshake nor stretches a pulse; the state register
  // itself only advances when en is high, so a pulse state simply waits.
  always_comb begin
    state_d                   = state_q;
    s_ready                   = 1'b0;
    start_mapping             = 1'b0;
    training_dataset_finished = 1'b0;
    testing_dataset_finished  = 1'b0;
    seq_done                  = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_LOAD;
      ST_LOAD: begin
        s_ready = en;
        if (s_valid && idx_q == LAST_IDX) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        start_mapping = en;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (sample_done) begin
          if (phase_q == PHASE_TRAIN && count_inc == TRAIN_LIM)     state_d = ST_TRAIN_END;
          else if (phase_q == PHASE_TEST && count_inc == TEST_LIM)  state_d = ST_TEST_END;
          else                                                      state_d = ST_LOAD;
        end
      end
      ST_TRAIN_END: begin
        training_dataset_finished = en;
        state_d                   = ST_GEN_WAIT;
      end
      ST_GEN_WAIT: if (class_gen_done) state_d = ST_LOAD;
      ST_TEST_END: begin
        testing_dataset_finished = en;
        state_d                  = ST_CORE_WAIT;
      end
      ST_CORE_WAIT: if (oneshot_hdc_done) state_d = ST_DONE;
      ST_DONE: begin
        seq_done = 1'b1;
        if (run) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, buffer and counters. The buffer is only written while loading,
  // which keeps the sample stable from launch until the core reports done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      phase_q <= PHASE_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      label_q <= '0;
      for (int i = 0; i < FEATURE_COUNT; i++) feat_q[i] <= '0;
    end else if (en) begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            phase_q <= PHASE_TRAIN;
            count_q <= '0;
            idx_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            feat_q[idx_q] <= s_feature;
            if (idx_q == '0) label_q <= s_label;
            idx_q <= next_idx(idx_q);
          end
        end
        ST_WAIT: if (sample_done) count_q <= count_inc;
        ST_GEN_WAIT: begin
          if (class_gen_done) begin
            phase_q <= PHASE_TEST;
            count_q <= '0;
          end
        end
        ST_CORE_WAIT: if (oneshot_hdc_done) phase_q <= PHASE_DONE;
        ST_DONE: begin
          if (run) begin
            phase_q <= PHASE_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            label_q <= '0;
            for (int i = 0; i < FEATURE_COUNT; i++) feat_q[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hdc_dataset_sequencer.md
HDC_DATASET_SEQUENCER -- requirements
Module: hdc_dataset_sequencer

Interface
REQ-001 SHALL have parameter TRAIN_COUNT, default 100, number of training samples per run (1..2047).
REQ-002 SHALL have parameter TEST_COUNT, default 100, number of testing samples per run (1..2047).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  global enable; when low, all state and outputs hold.
REQ-006 SHALL have port run  input  1  one-cycle pulse, starts a run from IDLE.
REQ-007 SHALL have port s_valid  input  1  host feature word valid.
REQ-008 SHALL have port s_ready  output  1  sequencer accepts a feature word.
REQ-009 SHALL have port s_feature  input  16  feature value, features sent in index order 0..FEATURE_COUNT-1.
REQ-010 SHALL have port s_label  input  5  class label, sampled with feature index 0.
REQ-011 SHALL have port input_values  output  16 x FEATURE_COUNT  assembled sample to the HDC core.
REQ-012 SHALL have port class_select_bits  output  5  label of the current sample.
REQ-013 SHALL have port start_mapping  output  1  one-cycle launch pulse.
REQ-014 SHALL have port sample_done  input  1  core encoding-done pulse.
REQ-015 SHALL have port class_gen_done  input  1  core class-HV generation complete.
REQ-016 SHALL have port training_dataset_finished / testing_dataset_finished  output  1 each  one-cycle phase-end pulses.
REQ-017 SHALL have port oneshot_hdc_done  input  1  core run complete.
REQ-018 SHALL have ports phase  output  2 (0 idle, 1 train, 2 test, 3 done); sample_count  output  11; seq_done  output  1.

Function
REQ-019 SHALL implement states IDLE, LOAD, LAUNCH, WAIT, TRAIN_END, GEN_WAIT, TEST_END, CORE_WAIT, DONE.
REQ-020 SHALL leave IDLE only on run=1 with en=1; enter LOAD with phase=1 and sample_count=0.
REQ-021 In LOAD, s_ready=1; each s_valid&s_ready cycle SHALL write s_feature to input_values[idx]; idx increments, wraps 0 after FEATURE_COUNT-1.
REQ-022 On the handshake with idx=0, s_label SHALL be captured into class_select_bits.
REQ-023 After the handshake with idx=FEATURE_COUNT-1, LOAD SHALL go to LAUNCH; s_ready=0 in every state except LOAD.
REQ-024 LAUNCH SHALL last exactly one cycle with start_mapping=1, then go to WAIT.
REQ-025 input_values and class_select_bits SHALL stay stable from LAUNCH until sample_done is seen.
REQ-026 In WAIT, sample_done=1 SHALL increment sample_count (11-bit, no wrap within range).
REQ-027 After sample_done, the next state SHALL be TRAIN_END if phase=1 and count=TRAIN_COUNT, TEST_END if phase=2 and count=TEST_COUNT, else LOAD.
REQ-028 sample_done outside WAIT SHALL be ignored.
REQ-029 TRAIN_END SHALL pulse training_dataset_finished for one cycle, then go to GEN_WAIT.
REQ-030 GEN_WAIT SHALL wait for class_gen_done=1, then go to LOAD with phase=2 and sample_count=0.
REQ-031 TEST_END SHALL pulse testing_dataset_finished for one cycle, then go to CORE_WAIT.
REQ-032 CORE_WAIT SHALL wait for oneshot_hdc_done=1, then go to DONE.
REQ-033 DONE SHALL assert seq_done=1 and phase=3, and return to IDLE (outputs cleared) on a run pulse.
REQ-034 run outside IDLE/DONE SHALL be ignored.
REQ-035 With en=0, handshakes SHALL NOT complete: s_ready is forced 0 and pulses are not issued or extended.

Reset
REQ-036 nrst=0 SHALL immediately force IDLE: all input_values 0, class_select_bits 0, idx 0, sample_count 0, phase 0, all pulses 0, s_ready 0, seq_done 0.
REQ-037 Reset mid-run SHALL discard the partial sample with no finished pulse emitted; a new run pulse is required.

Structure
REQ-038 FEATURE_COUNT and the phase encoding enum SHALL live in the shared HDC header package; the state enum stays local.
REQ-039 The module SHALL be flat with no sub-module; the feature buffer is a register array indexed by idx.

Verification
REQ-040 TRAIN_COUNT=2, TEST_COUNT=1, core stub returns sample_done 5 cycles after start_mapping -> exactly 3 start_mapping pulses, training_dataset_finished after the 2nd sample_done, testing pulse after the 3rd, seq_done once oneshot_hdc_done arrives.
REQ-041 Host toggles s_valid every other cycle -> input_values[i]=i+0x100 for all i, label 7 held on class_select_bits through WAIT.
REQ-042 sample_done injected during LOAD and GEN_WAIT -> sample_count unchanged.
REQ-043 en held 0 for 4 cycles inside LAUNCH -> start_mapping is a single pulse, delayed, state preserved.
REQ-044 nrst asserted while in WAIT of test phase -> all outputs 0 asynchronously; no testing_dataset_finished pulse; fresh run completes normally.
REQ-045 class_gen_done delayed 50 cycles -> s_ready=0 throughout, phase=1 until it arrives, then phase=2.
